register_file: RTL and testbench

//   Parametrised successor to the single REGISTER: a bank of DEPTH registers,

---
 rtl/register_file_pkg.sv | 8 +
 rtl/register_file_rd_port.sv | 65 ++++++
 rtl/register_file.sv | 94 +++++++++
 tb/tb_register_file.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared sizing constants for the general-purpose register store.
// Other blocks use these to size data and address fields consistently.
package register_file_pkg;

  localparam int DATA_BUS_LEN  = 8;
  localparam int REGFILE_DEPTH = 8;

endpackage

// File: rtl/register_file_rd_port.sv
// One registered read port: range check, write forwarding,
// zero-entry mask and the OUTPUT/VALID flops.
module register_file_rd_port
  import register_file_pkg::*;
#(
  parameter int WIDTH    = DATA_BUS_LEN,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wr_legal_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [WIDTH-1:0]  mem_i [DEPTH],
  output logic [WIDTH-1:0]  data_o,
  output logic              valid_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             in_range;
  logic             zero_hit;
  logic             fwd_hit;

  assign in_range = {1'b0, rd_addr_i} < DEPTH_C;
  assign zero_hit = (ZERO_REG != 0) && (rd_addr_i == '0);
  assign fwd_hit  = wr_legal_i && (wr_addr_i == rd_addr_i);

  // A clear at this edge wins over both storage and forwarding.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (rd_en_i) begin
      valid_d = 1'b1;
      if (clr_i || !in_range || zero_hit) begin
        data_d = '0;
      end else if (fwd_hit) begin
        data_d = wr_data_i;
      end else begin
        data_d = mem_i[rd_addr_i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/register_file.sv
// Register bank with one write port, two registered read ports,
// write forwarding, bulk clear and an optional hard-wired zero entry.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH    = DATA_BUS_LEN,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              WR,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  INPUT,
  input  logic              RD_EN_A,
  input  logic [ADDR_W-1:0] RD_ADDR_A,
  output logic [WIDTH-1:0]  OUTPUT_A,
  output logic              VALID_A,
  input  logic              RD_EN_B,
  input  logic [ADDR_W-1:0] RD_ADDR_B,
  output logic [WIDTH-1:0]  OUTPUT_B,
  output logic              VALID_B
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_in_range;
  logic             wr_zero;
  logic             wr_legal;

  assign wr_in_range = {1'b0, WR_ADDR} < DEPTH_C;
  assign wr_zero     = (ZERO_REG != 0) && (WR_ADDR == '0);
  assign wr_legal    = WR && wr_in_range && !wr_zero;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (CLR) begin
        mem_d[i] = '0;
      end else if (wr_legal && (WR_ADDR == ADDR_W'(i))) begin
        mem_d[i] = INPUT;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  register_file_rd_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH),
    .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
  ) u_rd_a (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (CLR),
    .wr_legal_i(wr_legal),
    .wr_addr_i (WR_ADDR),
    .wr_data_i (INPUT),
    .rd_en_i   (RD_EN_A),
    .rd_addr_i (RD_ADDR_A),
    .mem_i     (mem_q),
    .data_o    (OUTPUT_A),
    .valid_o   (VALID_A)
  );

  register_file_rd_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH),
    .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
  ) u_rd_b (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (CLR),
    .wr_legal_i(wr_legal),
    .wr_addr_i (WR_ADDR),
    .wr_data_i (INPUT),
    .rd_en_i   (RD_EN_B),
    .rd_addr_i (RD_ADDR_B),
    .mem_i     (mem_q),
    .data_o    (OUTPUT_B),
    .valid_o   (VALID_B)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: three configurations share one stimulus
// stream and are checked each cycle against an array model.
module tb_register_file;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       wr  = 1'b0;
  logic [2:0] wa  = '0;
  logic [7:0] din = '0;
  logic       rea = 1'b0;
  logic [2:0] raa = '0;
  logic       reb = 1'b0;
  logic [2:0] rab = '0;

  logic [7:0] oa0, ob0, oa1, ob1, oa2, ob2;
  logic       va0, vb0, va1, vb1, va2, vb2;

  int checks   = 0;
  int failures = 0;

  int dep [3] = '{8, 8, 6};
  int zr  [3] = '{0, 1, 0};
  int m   [3][8];
  int eo  [3][2];
  int ev  [3][2];

  always #5 clk = ~clk;

  register_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) u_d8 (
    .CLK(clk), .RST(rst), .CLR(clr), .WR(wr), .WR_ADDR(wa),
    .INPUT(din), .RD_EN_A(rea), .RD_ADDR_A(raa),
    .OUTPUT_A(oa0), .VALID_A(va0), .RD_EN_B(reb),
    .RD_ADDR_B(rab), .OUTPUT_B(ob0), .VALID_B(vb0)
  );

  register_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) u_zr (
    .CLK(clk), .RST(rst), .CLR(clr), .WR(wr), .WR_ADDR(wa),
    .INPUT(din), .RD_EN_A(rea), .RD_ADDR_A(raa),
    .OUTPUT_A(oa1), .VALID_A(va1), .RD_EN_B(reb),
    .RD_ADDR_B(rab), .OUTPUT_B(ob1), .VALID_B(vb1)
  );

  register_file #(.WIDTH(8), .DEPTH(6), .ZERO_REG(0)) u_d6 (
    .CLK(clk), .RST(rst), .CLR(clr), .WR(wr), .WR_ADDR(wa),
    .INPUT(din), .RD_EN_A(rea), .RD_ADDR_A(raa),
    .OUTPUT_A(oa2), .VALID_A(va2), .RD_EN_B(reb),
    .RD_ADDR_B(rab), .OUTPUT_B(ob2), .VALID_B(vb2)
  );

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Value a read of address ra returns in configuration k.
  function automatic int rd_val(int k, int ra, bit legal);
    if (clr || ra >= dep[k] || (zr[k] != 0 && ra == 0))
      return 0;
    if (legal && int'(wa) == ra)
      return int'(din);
    return m[k][ra];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit legal;
      legal = wr && int'(wa) < dep[k] &&
              !(zr[k] != 0 && wa == 0);
      ev[k][0] = rea ? 1 : 0;
      ev[k][1] = reb ? 1 : 0;
      if (rea) eo[k][0] = rd_val(k, int'(raa), legal);
      if (reb) eo[k][1] = rd_val(k, int'(rab), legal);
      if (clr) begin
        for (int i = 0; i < 8; i++) m[k][i] = 0;
      end else if (legal) begin
        m[k][int'(wa)] = int'(din);
      end
    end
  endtask

  task automatic cmp_dut(int k, logic [7:0] a, logic [7:0] b,
                         logic av, logic bv);
    check($sformatf("m%0d_outa", k), {24'd0, a}, eo[k][0]);
    check($sformatf("m%0d_outb", k), {24'd0, b}, eo[k][1]);
    check($sformatf("m%0d_va", k), {31'd0, av}, ev[k][0]);
    check($sformatf("m%0d_vb", k), {31'd0, bv}, ev[k][1]);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 8; i++) m[k][i] = 0;
        eo[k][0] = 0; eo[k][1] = 0;
        ev[k][0] = 0; ev[k][1] = 0;
      end
    end else begin
      model_edge();
    end
    #1;
    cmp_dut(0, oa0, ob0, va0, vb0);
    cmp_dut(1, oa1, ob1, va1, vb1);
    cmp_dut(2, oa2, ob2, va2, vb2);
  end

  task automatic step(logic w, logic [2:0] a, logic [7:0] d,
                      logic ea, logic [2:0] aa,
                      logic eb, logic [2:0] ab, logic c);
    wr = w; wa = a; din = d;
    rea = ea; raa = aa;
    reb = eb; rab = ab;
    clr = c;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_outa", {24'd0, oa0}, 0);
    check("rst_va", {31'd0, va0}, 0);
    rst = 1'b0;
    idle();

    // Write then read one cycle later.
    step(1, 3, 8'hA5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0, 0);
    check("rd3_outa", {24'd0, oa0}, 32'hA5);
    check("rd3_va", {31'd0, va0}, 1);
    idle();
    check("rd3_va_drop", {31'd0, va0}, 0);
    check("rd3_hold", {24'd0, oa0}, 32'hA5);

    // Forwarding on both ports.
    step(1, 5, 8'h99, 0, 0, 0, 0, 0);
    step(1, 5, 8'h3C, 1, 5, 1, 5, 0);
    check("fwd_a", {24'd0, oa0}, 32'h3C);
    check("fwd_b", {24'd0, ob0}, 32'h3C);
    check("fwd_d6", {24'd0, ob2}, 32'h3C);

    // Hard-wired zero entry.
    step(1, 0, 8'h5A, 1, 0, 0, 0, 0);
    check("zr_same", {24'd0, oa1}, 0);
    check("nozr_fwd", {24'd0, oa0}, 32'h5A);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    check("zr_next", {24'd0, oa1}, 0);
    check("zr_valid", {31'd0, va1}, 1);
    check("nozr_next", {24'd0, oa0}, 32'h5A);

    // Out-of-range entry on the 6-deep bank.
    step(1, 7, 8'h77, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 7, 0);
    check("oor_outb", {24'd0, ob2}, 0);
    check("oor_vb", {31'd0, vb2}, 1);
    check("d8_e7", {24'd0, ob0}, 32'h77);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, 3'(i), 0, 0, 0);
      if (i == 3) check("d6_e3", {24'd0, oa2}, 32'hA5);
      if (i == 5) check("d6_e5", {24'd0, oa2}, 32'h3C);
    end

    // Fill, then clear together with a write.
    for (int i = 0; i < 8; i++)
      step(1, 3'(i), 8'((i + 1) * 17), 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 6, 0, 0, 0);
    check("fill_e6", {24'd0, oa0}, 32'h77);
    step(1, 2, 8'hFF, 1, 2, 1, 2, 1);
    check("clr_a", {24'd0, oa0}, 0);
    check("clr_b", {24'd0, ob0}, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 3'(i), 1, 3'(7 - i), 0);
      check("clr_rd", {24'd0, oa0}, 0);
    end

    // Asynchronous reset mid-run with traffic in flight.
    step(1, 4, 8'h42, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4, 1, 4, 0);
    check("pre_rst", {24'd0, ob0}, 32'h42);
    wr = 1; wa = 6; din = 8'h66;
    rea = 1; raa = 4; reb = 1; rab = 4;
    rst = 1'b1;
    #1;
    check("arst_outa", {24'd0, oa0}, 0);
    check("arst_outb", {24'd0, ob0}, 0);
    check("arst_va", {31'd0, va0}, 0);
    check("arst_vb", {31'd0, vb0}, 0);
    @(posedge clk);
    #2;
    check("arst_hold", {24'd0, oa0}, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 3'(i), 1, 3'(i), 0);
      check("post_rst", {24'd0, oa0}, 0);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
